count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 32: cycles count_in may stay unchanged in RUN before a stall error is raised; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port go  input  1  request to begin a run; sampled only in IDLE.
REQ-005 SHALL have port target  input  4  count value at which the run ends; latched on accepted go.
REQ-006 SHALL have port abort  input  1  ends an active run early.
REQ-007 SHALL have port count_in  input  4  count value returned by the start/stop counter.
REQ-008 SHALL have port start  output  1  one-cycle pulse that enables the counter.
REQ-009 SHALL have port stop  output  1  one-cycle pulse that halts the counter.
REQ-010 SHALL have port busy  output  1  high from the cycle after go is accepted until done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port result  output  4  count_in captured at the terminating event; held until the next accepted go.
REQ-013 SHALL have port wraps  output  4  number of 15->0 transitions of count_in seen during the run; saturates at 15.
REQ-014 SHALL have port status  output  2  outcome, held with result: 00 hit, 01 aborted, 10 stalled.

Function
REQ-015 SHALL implement states IDLE, START, RUN, STOP, DONE.
REQ-016 IDLE: go=1 -> latch target, clear wraps and stall timer, go to START; go=0 -> stay.
REQ-017 START: start=1 for exactly this cycle; then RUN unconditionally.
REQ-018 RUN: count_in == latched target -> capture result, status=00, go to STOP.
REQ-019 RUN: abort=1 -> capture result, status=01, go to STOP; abort takes priority over a simultaneous target match.
REQ-020 RUN: stall timer reaches STALL_LIMIT -> capture result, status=10, go to STOP; abort takes priority over stall, and stall takes priority over match.
REQ-021 The target comparison SHALL be ignored in the first RUN cycle so that a target equal to the pre-start count_in does not end the run immediately.
REQ-022 Stall timer: cleared whenever count_in differs from its previous-cycle value, otherwise incremented each RUN cycle.
REQ-023 wraps SHALL increment when the previous count_in is 15 and the current count_in is 0, counted only in RUN, and SHALL saturate at 15.
REQ-024 STOP: stop=1 for exactly this cycle; then DONE.
REQ-025 DONE: done=1 for exactly this cycle, busy=0; then IDLE.
REQ-026 go asserted in any state other than IDLE SHALL be ignored; abort outside RUN SHALL be ignored.
REQ-027 start and stop SHALL never be high in the same cycle; busy=1 in START, RUN and STOP.
REQ-028 Minimum go-to-done latency SHALL be 4 cycles: START, a single RUN cycle, STOP, DONE.

Reset
REQ-029 reset SHALL force state IDLE and start=0, stop=0, busy=0, done=0, result=0, wraps=0, status=00, and clear the stall timer and target register.
REQ-030 reset asserted mid-run SHALL abandon the run without emitting stop or done.

Structure
REQ-031 A shared package count_seq_pkg SHALL hold the state encoding, the status codes and the STALL_LIMIT default.
REQ-032 The stall timer and its comparator SHALL be one sub-module, stall_watchdog (inputs clk, reset, clear, enable, count_in; output expired).

Verification
REQ-033 go with target=5, count_in incrementing from 0 after start -> stop pulse 1 cycle after count_in=5, then done, result=5, status=00, wraps=0.
REQ-034 target=2, count_in runs 3..15,0,1,2 -> wraps=1, result=2, status=00.
REQ-035 abort in the 3rd RUN cycle with count_in=2 -> stop then done, result=2, status=01; an abort in the same cycle as a target match also yields status=01.
REQ-036 count_in frozen at 7 after start, STALL_LIMIT=32 -> stop after 32 unchanged RUN cycles, result=7, status=10.
REQ-037 reset pulsed while in RUN -> all outputs 0 immediately, no stop or done afterwards; a new go 2 cycles later runs normally.
REQ-038 go held high across DONE -> a second run starts only from IDLE, and busy is low in the DONE cycle.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM encoding, outcome codes,
// count width and the default stall limit.
package count_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STAT_HIT   = 2'b00,
    STAT_ABORT = 2'b01,
    STAT_STALL = 2'b10
  } status_e;

  localparam int CNT_W           = 4;
  localparam int STALL_LIMIT_DEF = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive enabled cycles in which count_in has not moved and flags
// the cycle in which that run of unchanged samples reaches STALL_LIMIT.
module stall_watchdog
  import count_seq_pkg::*;
#(
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] count_in,
  output logic             expired
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] prev_q;
  logic             same;

  assign same = (count_in == prev_q);

  // timer_q holds the unchanged cycles already seen, so the current cycle is the LIMIT-th when it equals LIMIT-1
  assign expired = enable && same && (timer_q >= (LIMIT - 8'd1));

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable) begin
      if (!same)                timer_d = '0;
      else if (timer_q != LIMIT) timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      prev_q  <= '0;
    end else begin
      timer_q <= timer_d;
      prev_q  <= count_in;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequences an external start/stop counter: pulses start, watches count_in for
// target / abort / stall, pulses stop, then reports result, wraps and status.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] target,
  input  logic             abort,
  input  logic [CNT_W-1:0] count_in,
  output logic             start,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic [CNT_W-1:0] wraps,
  output logic [1:0]       status
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] wraps_q, wraps_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] prev_q;
  logic             first_q;
  logic             go_acc, in_run, hit, wrap, expired, term;

  assign go_acc = (state_q == S_IDLE) && go;
  assign in_run = (state_q == S_RUN);
  // first_q masks the match so a target equal to the idle count cannot end the run at once
  assign hit    = in_run && !first_q && (count_in == target_q);
  assign wrap   = in_run && (prev_q == CNT_MAX) && (count_in == '0);
  assign term   = in_run && (abort || expired || hit);

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (go_acc),
    .enable  (in_run),
    .count_in(count_in),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (term) state_d = S_STOP;
      S_STOP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    stop  = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_START: begin start = 1'b1; busy = 1'b1; end
      S_RUN:   busy = 1'b1;
      S_STOP:  begin stop = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    target_d = target_q;
    wraps_d  = wraps_q;
    result_d = result_q;
    status_d = status_q;
    if (go_acc) begin
      target_d = target;
      wraps_d  = '0;
    end
    if (wrap) wraps_d = sat_inc(wraps_q);
    // abort outranks stall, stall outranks a plain match
    if (term) begin
      result_d = count_in;
      if (abort)        status_d = STAT_ABORT;
      else if (expired) status_d = STAT_STALL;
      else              status_d = STAT_HIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= '0;
      wraps_q  <= '0;
      result_q <= '0;
      status_q <= STAT_HIT;
      prev_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      wraps_q  <= wraps_d;
      result_q <= result_d;
      status_q <= status_d;
      prev_q   <= count_in;
      first_q  <= (state_q == S_START);
    end
  end

  assign result = result_q;
  assign wraps  = wraps_q;
  assign status = status_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: directed runs push expected outcomes,
// a negedge monitor pops and compares on every done pulse.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [3:0] target = 4'd0;
  logic       abort = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       start, stop, busy, done;
  logic [3:0] result, wraps;
  logic [1:0] status;

  count_sequencer dut (
    .clk(clk), .reset(reset), .go(go), .target(target), .abort(abort),
    .count_in(count_in), .start(start), .stop(stop), .busy(busy),
    .done(done), .result(result), .wraps(wraps), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] result;
    logic [1:0] status;
    logic [3:0] wraps;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e_mon;
  logic [3:0] seq [64];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int n_start = 0, n_stop = 0, n_done = 0;
  int start_cyc = 0, stop_cyc = 0, done_cyc = 0, start_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int r, input int s, input int w, input int l);
    exp_t e;
    e.result = 4'(r);
    e.status = 2'(s);
    e.wraps  = 4'(w);
    e.lat    = l;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      chk("start_stop_exclusive", int'(start & stop), 0);
      if (start) begin
        start_gap = cyc - done_cyc;
        start_cyc = cyc;
        n_start++;
      end
      if (stop) begin
        chk("busy_in_stop", int'(busy), 1);
        stop_cyc = cyc;
        n_stop++;
      end
      if (done) begin
        done_cyc = cyc;
        n_done++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
        end else begin
          e_mon = sb_q.pop_front();
          chk("result", int'(result), int'(e_mon.result));
          chk("status", int'(status), int'(e_mon.status));
          chk("wraps", int'(wraps), int'(e_mon.wraps));
          chk("latency", cyc - start_cyc + 1, e_mon.lat);
          chk("stop_before_done", stop_cyc, cyc - 1);
          chk("busy_in_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic fill_ramp(input int s);
    for (int i = 0; i < 64; i++) seq[i] = 4'((s + i) % 16);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 64; i++) seq[i] = 4'(v);
  endtask

  // One run: go with tgt while count_in=pre, START holds pre, RUN cycle i+1 sees seq[i]
  task automatic do_run(input int tgt, input int pre, input int abort_idx, input exp_t e);
    int base;
    base = n_done;
    sb_q.push_back(e);
    @(posedge clk); #1;
    count_in = 4'(pre);
    target   = 4'(tgt);
    go       = 1'b1;
    @(posedge clk); #1;
    go     = 1'b0;
    target = ~4'(tgt);
    for (int i = 0; i < 200 && n_done == base; i++) begin
      @(posedge clk); #1;
      count_in = seq[(i < 64) ? i : 63];
      abort    = (i == abort_idx);
    end
    abort = 1'b0;
    chk("run_completed", n_done - base, 1);
    chk("result_hold", int'(result), int'(e.result));
    chk("status_hold", int'(status), int'(e.status));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},  int'(start), 0);
    chk({tag, "_stop"},   int'(stop), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_done"},   int'(done), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_status"}, int'(status), 0);
    chk({tag, "_wraps"},  int'(wraps), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int ns, nd, bs, bd;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b0;

    // target 5, ramp from 0: six RUN cycles
    fill_ramp(0);
    do_run(5, 0, -1, mk(5, 0, 0, 9));
    // target 2 reached after a 15->0 wrap
    fill_ramp(3);
    do_run(2, 0, -1, mk(2, 0, 1, 19));
    // abort in third RUN cycle
    fill_ramp(0);
    do_run(9, 0, 2, mk(2, 1, 0, 6));

    // reset mid-run with wraps=1 and result/status nonzero
    fill_ramp(14);
    @(posedge clk); #1;
    count_in = 4'd13; target = 4'd9; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      count_in = seq[i];
    end
    chk("busy_before_reset", int'(busy), 1);
    chk("wraps_before_reset", int'(wraps), 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrun");
    @(posedge clk); #1;
    reset = 1'b0;
    ns = n_stop;
    nd = n_done;
    repeat (2) @(posedge clk);
    #1;
    chk("no_stop_after_reset", n_stop - ns, 0);
    chk("no_done_after_reset", n_done - nd, 0);
    fill_ramp(0);
    do_run(5, 0, -1, mk(5, 0, 0, 9));

    // abort coinciding with target match
    fill_ramp(1);
    do_run(4, 0, 3, mk(4, 1, 0, 7));
    // target equals pre-start count: first RUN cycle must not end the run
    fill_ramp(5);
    do_run(5, 5, -1, mk(5, 0, 1, 20));
    // frozen count: stall after 32 unchanged RUN cycles
    fill_const(7);
    do_run(9, 7, -1, mk(7, 2, 0, 35));
    // timer cleared by go and by a count change
    for (int i = 0; i < 64; i++) seq[i] = (i < 20) ? 4'd1 : 4'd2;
    do_run(9, 1, -1, mk(2, 2, 0, 56));
    // abort in the stall cycle wins
    fill_const(3);
    do_run(9, 3, 31, mk(3, 1, 0, 35));
    // 18 wraps saturate at 15
    for (int i = 0; i < 64; i++) seq[i] = (i % 2 == 0) ? 4'd15 : 4'd0;
    do_run(9, 0, 35, mk(0, 1, 15, 39));

    // go and abort held across DONE: two minimal runs, restart only via IDLE
    sb_q.push_back(mk(6, 1, 0, 4));
    sb_q.push_back(mk(6, 1, 0, 4));
    bs = n_start;
    bd = n_done;
    @(posedge clk); #1;
    count_in = 4'd6; target = 4'd9; go = 1'b1; abort = 1'b1;
    for (int i = 0; i < 50 && n_start < bs + 2; i++) begin
      @(posedge clk); #1;
    end
    go = 1'b0;
    chk("go_held_starts", n_start - bs, 2);
    chk("go_held_restart_gap", start_gap, 2);
    for (int i = 0; i < 50 && n_done < bd + 2; i++) begin
      @(posedge clk); #1;
    end
    abort = 1'b0;
    chk("go_held_dones", n_done - bd, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_go_drop", int'(busy), 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
